// File: rtl/ahblite_lcd_seq_pkg.sv
// lcd_seq_pkg: register map, sequencer states and field layout shared by the LCD sequencer.
package lcd_seq_pkg;
  localparam logic [2:0] A_CMD       = 3'd0;
  localparam logic [2:0] A_DATA      = 3'd1;
  localparam logic [2:0] A_FILL_DATA = 3'd2;
  localparam logic [2:0] A_FILL_CNT  = 3'd3;
  localparam logic [2:0] A_TIMING    = 3'd4;
  localparam logic [2:0] A_STATUS    = 3'd5;
  localparam logic [2:0] A_CTRL      = 3'd6;
  localparam int T_LO_LSB = 0;
  localparam int T_HI_LSB = 4;
  localparam int T_W      = 4;
  localparam int ENTRY_W  = 17;
  typedef enum logic [1:0] {IDLE, SETUP, WR_LO, WR_HI} state_t;
endpackage

// File: rtl/ahblite_lcd_seq_if.sv
// ahblite_lcd_seq_if: AHB-Lite slave-side bus bundle for the LCD sequencer.
interface ahblite_lcd_seq_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  modport slave (input HSEL, HTRANS, HWRITE, HREADY, HSIZE, HPROT, HADDR, HWDATA,
                 output HREADYOUT, HRDATA, HRESP);
  modport master (output HSEL, HTRANS, HWRITE, HREADY, HSIZE, HPROT, HADDR, HWDATA,
                  input HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/ahblite_lcd_seq_fifo.sv
// lcd_seq_fifo: synchronous command/data FIFO; caller guarantees no push when full without a pop.
module lcd_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 17
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   lvl_q;
  always_ff @(posedge HCLK)
    if (push_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      lvl_q <= lvl_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign rdata_o = mem_q[rp_q];
  assign full_o  = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
endmodule

// File: rtl/ahblite_lcd_seq.sv
// ahblite_lcd_seq: AHB-Lite slave that turns FIFO'd commands/data and fill runs into 8080 LCD strobes.
module ahblite_lcd_seq
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahblite_lcd_seq_if.slave  bus,
  output logic              LCD_CS,
  output logic              LCD_RS,
  output logic              LCD_WR,
  output logic              LCD_RD,
  output logic [15:0]       LCD_DATA,
  output logic              LCD_RST,
  output logic              LCD_BL_CTR
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t             st_q, st_d;
  logic               act_q, wr_q;
  logic [2:0]         a_q;
  logic [15:0]        fdat_q;
  logic [7:0]         tim_q;
  logic [1:0]         ctrl_q;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [T_W-1:0]     tlo_q, tlo_d, thi_q, thi_d, cnt_q, cnt_d;
  logic               rs_q, rs_d;
  logic [15:0]        dat_q, dat_d;
  logic               push, pop, full, empty, go;
  logic [ENTRY_W-1:0] fifo_rd;
  logic [LW-1:0]      lvl;
  logic               fill_act, ready, wr_ph, fifo_wr, fill_wr, drain_ok, hready, commit, busy;
  logic [31:0]        status;
  logic               unused;

  lcd_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .HCLK(HCLK), .HRESETn(HRESETn), .push_i(push),
    .wdata_i({a_q == A_DATA, bus.HWDATA[15:0]}), .pop_i(pop),
    .rdata_o(fifo_rd), .full_o(full), .empty_o(empty), .level_o(lvl)
  );

  assign fill_act = |fcnt_q;
  assign ready    = fill_act | ~empty;
  assign wr_ph    = act_q & wr_q;
  assign fifo_wr  = wr_ph & (a_q == A_CMD | a_q == A_DATA);
  assign fill_wr  = wr_ph & a_q == A_FILL_CNT;
  assign drain_ok = empty & st_q == IDLE & ~fill_act;
  // A stalled push may complete in the very cycle a pop frees the slot.
  assign hready   = ~(fifo_wr & full & ~pop) & ~(fill_wr & ~drain_ok);
  assign commit   = wr_ph & hready;
  assign push     = fifo_wr & hready;
  assign busy     = st_q != IDLE | fill_act | ~empty;
  assign status   = 32'({lvl, 5'd0, empty, full, busy});

  assign bus.HREADYOUT = hready;
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA    = !(act_q && !wr_q)     ? '0 :
                         a_q == A_FILL_DATA    ? {16'd0, fdat_q} :
                         a_q == A_TIMING       ? {24'd0, tim_q} :
                         a_q == A_STATUS       ? status :
                         a_q == A_CTRL         ? {30'd0, ctrl_q} : '0;
  assign unused = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:16], bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      a_q    <= '0;
      fdat_q <= '0;
      tim_q  <= '0;
      ctrl_q <= '0;
    end else begin
      if (bus.HREADY) begin
        act_q <= bus.HSEL & bus.HTRANS[1];
        wr_q  <= bus.HWRITE;
        a_q   <= bus.HADDR[4:2];
      end
      if (commit && a_q == A_FILL_DATA) fdat_q <= bus.HWDATA[15:0];
      if (commit && a_q == A_TIMING) tim_q <= bus.HWDATA[7:0];
      if (commit && a_q == A_CTRL) ctrl_q <= bus.HWDATA[1:0];
    end

  // A running fill owns the bus until it finishes; FIFO words queue behind it.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    tlo_d  = tlo_q;
    thi_d  = thi_q;
    rs_d   = rs_q;
    dat_d  = dat_q;
    fcnt_d = fcnt_q;
    pop    = 1'b0;
    go     = ready & (st_q == IDLE | (st_q == WR_HI & cnt_q == '0));
    if (st_q == SETUP) begin
      st_d  = WR_LO;
      cnt_d = tlo_q;
    end else if (st_q == WR_LO) begin
      st_d  = cnt_q == '0 ? WR_HI : WR_LO;
      cnt_d = cnt_q == '0 ? thi_q : cnt_q - 1'b1;
    end else if (st_q == WR_HI) begin
      st_d  = cnt_q == '0 ? IDLE : WR_HI;
      cnt_d = cnt_q - 1'b1;
    end
    if (go) begin
      st_d   = SETUP;
      tlo_d  = tim_q[T_LO_LSB +: T_W];
      thi_d  = tim_q[T_HI_LSB +: T_W];
      pop    = ~fill_act;
      fcnt_d = fill_act ? fcnt_q - 1'b1 : fcnt_q;
      rs_d   = fill_act | fifo_rd[16];
      dat_d  = fill_act ? fdat_q : fifo_rd[15:0];
    end
    if (fill_wr && drain_ok) fcnt_d = bus.HWDATA[CNT_W-1:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      tlo_q  <= '0;
      thi_q  <= '0;
      rs_q   <= 1'b0;
      dat_q  <= '0;
      fcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tlo_q  <= tlo_d;
      thi_q  <= thi_d;
      rs_q   <= rs_d;
      dat_q  <= dat_d;
      fcnt_q <= fcnt_d;
    end

  assign LCD_CS     = st_q == IDLE;
  assign LCD_WR     = st_q != WR_LO;
  assign LCD_RD     = 1'b1;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = dat_q;
  assign LCD_RST    = ctrl_q[0];
  assign LCD_BL_CTR = ctrl_q[1];
endmodule

// File: tb/tb_ahblite_lcd_seq.sv
// tb_ahblite_lcd_seq: directed + randomized bench; words seen on the panel bus are matched to an expected queue.
module tb_ahblite_lcd_seq;
  localparam logic [31:0] R_CMD = 32'h00, R_DATA = 32'h04, R_FILLD = 32'h08, R_FILLC = 32'h0C;
  localparam logic [31:0] R_TIM = 32'h10, R_STAT = 32'h14, R_CTRL = 32'h18;

  typedef struct {logic [16:0] w; int lo; int fall; int per; bit contig;} mon_t;

  logic HCLK = 1'b0, HRESETn;
  logic lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_bl;
  logic [15:0] lcd_data;
  int cyc = 0, ncmp = 0, nerr = 0;
  mon_t got[$];
  logic [16:0] exp_q[$];
  int prev_wr = 1, lo_cnt = 0, fall_cyc = 0, last_fall = 0, cs_high = 1, push_cyc = 0;

  ahblite_lcd_seq_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahblite_lcd_seq #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .LCD_CS(lcd_cs), .LCD_RS(lcd_rs), .LCD_WR(lcd_wr), .LCD_RD(lcd_rd),
    .LCD_DATA(lcd_data), .LCD_RST(lcd_rst), .LCD_BL_CTR(lcd_bl)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Panel-side view: one record per WR rising edge, with low width and fall-to-fall spacing.
  always @(negedge HCLK) begin
    mon_t m;
    if (!HRESETn) begin
      prev_wr = 1; lo_cnt = 0; cs_high = 1;
    end else begin
      if (lcd_cs) cs_high = 1;
      if (!lcd_wr) begin
        if (prev_wr != 0) fall_cyc = cyc;
        lo_cnt++;
      end else if (prev_wr == 0) begin
        m.w = {lcd_rs, lcd_data}; m.lo = lo_cnt; m.fall = fall_cyc;
        m.per = fall_cyc - last_fall; m.contig = (cs_high == 0);
        got.push_back(m);
        last_fall = fall_cyc; lo_cnt = 0; cs_high = 0;
      end
      prev_wr = lcd_wr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int stall);
    @(posedge HCLK); #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 1; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0; bus.HWDATA = d;
    stall = 0;
    while (bus.HREADYOUT !== 1'b1 && stall < 3000) begin
      @(posedge HCLK); #1;
      stall++;
    end
    if (stall >= 3000) chk("write_timeout", {31'd0, bus.HREADYOUT}, 32'd1);
    push_cyc = cyc + 1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int s;
    ahb_write(a, d, s);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 0; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (got.size() < n && k < 5000) begin
      @(posedge HCLK);
      k++;
    end
  endtask

  task automatic drain_check(input string tag, input int tlo, input int thi);
    mon_t m;
    logic [16:0] e;
    wait_words(exp_q.size());
    repeat (40) @(posedge HCLK);
    chk({tag, "_count"}, got.size(), exp_q.size());
    while (exp_q.size() > 0 && got.size() > 0) begin
      m = got.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_word"}, {15'd0, m.w}, {15'd0, e});
      chk({tag, "_wr_lo"}, m.lo, tlo + 1);
      if (m.contig) chk({tag, "_period"}, m.per, 3 + tlo + thi);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic pins_reset(input string tag);
    chk({tag, "_cs"}, {31'd0, lcd_cs}, 32'd1);
    chk({tag, "_wr"}, {31'd0, lcd_wr}, 32'd1);
    chk({tag, "_rd"}, {31'd0, lcd_rd}, 32'd1);
    chk({tag, "_rs_data"}, {15'd0, lcd_rs, lcd_data}, 32'd0);
    chk({tag, "_rst_bl"}, {30'd0, lcd_rst, lcd_bl}, 32'd0);
    chk({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'd1);
    chk({tag, "_hrdata"}, bus.HRDATA, 32'd0);
  endtask

  initial begin
    int s, n, tlo, thi, nf, nw;
    logic [31:0] d, fd;
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HSIZE = 3'd2; bus.HPROT = 4'd3;
    bus.HADDR = 0; bus.HWDATA = 0;
    HRESETn = 0;
    repeat (3) @(posedge HCLK);
    #1;
    pins_reset("in_reset");
    HRESETn = 1;
    pins_reset("after_reset");
    rd_chk("status_reset", R_STAT, 32'h4);
    rd_chk("timing_reset", R_TIM, 32'h0);
    rd_chk("filld_reset", R_FILLD, 32'h0);
    rd_chk("unmapped_read", 32'h1C, 32'h0);
    wr(R_CTRL, 32'h3);
    @(posedge HCLK); #1;
    chk("ctrl_pins", {30'd0, lcd_rst, lcd_bl}, 32'h3);
    rd_chk("ctrl_read", R_CTRL, 32'h3);

    // Two-word burst at minimum timing.
    wr(R_TIM, 32'h00);
    wr(R_CMD, 32'h002C);
    n = push_cyc;
    wr(R_DATA, 32'hF800);
    exp_q.push_back(17'h0002C);
    exp_q.push_back(17'h1F800);
    wait_words(2);
    chk("first_wr_latency", got[0].fall - n, 32'd2);
    chk("cs_low_across", {31'd0, got[1].contig}, 32'd1);
    drain_check("t00", 0, 0);

    wr(R_TIM, 32'h21);
    rd_chk("timing_read", R_TIM, 32'h21);
    wr(R_DATA, 32'h0001);
    wr(R_CMD, 32'h0002);
    wr(R_DATA, 32'h0003);
    exp_q.push_back(17'h10001);
    exp_q.push_back(17'h00002);
    exp_q.push_back(17'h10003);
    drain_check("t21", 1, 2);

    // Fill then a queued data word; then an empty fill.
    wr(R_TIM, 32'h00);
    wr(R_FILLD, 32'h07E0);
    rd_chk("filld_read", R_FILLD, 32'h07E0);
    wr(R_FILLC, 32'd5);
    wr(R_DATA, 32'h1234);
    repeat (5) exp_q.push_back(17'h107E0);
    exp_q.push_back(17'h11234);
    drain_check("fill5", 0, 0);
    wr(R_FILLC, 32'd0);
    repeat (30) @(posedge HCLK);
    chk("fill0_no_strobes", got.size(), 32'd0);
    rd_chk("fill0_status", R_STAT, 32'h4);

    // A long fill holds the engine so the FIFO fills up and the ninth write stalls.
    wr(R_TIM, 32'h33);
    fd = $urandom;
    wr(R_FILLD, {16'd0, fd[15:0]});
    wr(R_FILLC, 32'd10);
    repeat (10) exp_q.push_back({1'b1, fd[15:0]});
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      ahb_write(R_DATA, {16'd0, d[15:0]}, s);
      exp_q.push_back({1'b1, d[15:0]});
      chk("no_stall_before_full", s, 32'd0);
    end
    rd_chk("status_full", R_STAT, 32'h0803);
    d = $urandom;
    ahb_write(R_DATA, {16'd0, d[15:0]}, s);
    exp_q.push_back({1'b1, d[15:0]});
    chk("ninth_write_stalled", {31'd0, s > 0}, 32'd1);
    rd_chk("status_push_pop_full", R_STAT, 32'h0803);
    drain_check("full", 3, 3);

    // Randomized rounds: random timing, optional fill, random CMD/DATA mix.
    for (int r = 0; r < 4; r++) begin
      tlo = $urandom_range(0, 3);
      thi = $urandom_range(0, 3);
      wr(R_TIM, 32'(thi * 16 + tlo));
      nf = $urandom_range(0, 4);
      fd = $urandom;
      wr(R_FILLD, {16'd0, fd[15:0]});
      wr(R_FILLC, 32'(nf));
      repeat (nf) exp_q.push_back({1'b1, fd[15:0]});
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        d = $urandom;
        wr(d[16] ? R_DATA : R_CMD, {16'd0, d[15:0]});
        exp_q.push_back(d[16:0]);
      end
      drain_check("rand", tlo, thi);
    end

    // Reset in the middle of a burst.
    wr(R_TIM, 32'h33);
    for (int i = 0; i < 4; i++) wr(R_DATA, 32'(16'hA000 + i));
    n = 0;
    while (lcd_wr !== 1'b0 && n < 500) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk("burst_wr_low_seen", {31'd0, lcd_wr}, 32'd0);
    HRESETn = 0;
    #1;
    pins_reset("mid_reset");
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1;
    got.delete();
    exp_q.delete();
    repeat (60) @(posedge HCLK);
    chk("no_residual_strobes", got.size(), 32'd0);
    rd_chk("status_after_abort", R_STAT, 32'h4);
    rd_chk("timing_after_abort", R_TIM, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
